// File: rtl/mul_ctrl.sv
// Sequencing controller for the radix-4 Booth / Wallace-tree RV64M multiplier:
// accepts one request, extends operands to 66 bits, launches the datapath, waits out its latency, returns the result.
module mul_ctrl #(
  parameter int unsigned LATENCY = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [2:0]   io_in_op,
  input  logic [63:0]  io_in_src1,
  input  logic [63:0]  io_in_src2,
  input  logic         io_flush,
  output logic         io_dp_valid,
  output logic [65:0]  io_dp_src1,
  output logic [65:0]  io_dp_src2,
  input  logic [131:0] io_dp_res,
  output logic         io_out_valid,
  input  logic         io_out_ready,
  output logic [63:0]  io_out_result,
  output logic         io_busy
);

  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [2:0]  op;
  logic        accept;
  logic        capture;
  logic        src1_signed;
  logic        src2_signed;
  logic        is_word;
  logic        unused_res_hi;

  // Extend a 64-bit source to the 66-bit Booth operand width.
  function automatic logic [65:0] extend_operand(input logic [63:0] v,
                                                 input logic        sgn,
                                                 input logic        word);
    logic [65:0] r;
    if (word) begin
      r = {{34{v[31]}}, v[31:0]};
    end else if (sgn) begin
      r = {{2{v[63]}}, v};
    end else begin
      r = {2'b00, v};
    end
    return r;
  endfunction

  function automatic logic [63:0] select_result(input logic [2:0]   o,
                                                input logic [127:0] r);
    logic [63:0] s;
    case (o)
      OP_MULH, OP_MULHSU, OP_MULHU: s = r[127:64];
      OP_MULW:                      s = {{32{r[31]}}, r[31:0]};
      default:                      s = r[63:0];
    endcase
    return s;
  endfunction

  // Bits above the 128-bit product carry no information.
  assign unused_res_hi = ^io_dp_res[131:128];

  // Handshake and status decode; a flush blocks acceptance and kills a pending launch strobe.
  always_comb begin
    io_in_ready  = ~io_flush & ((state == IDLE) | ((state == DONE) & io_out_ready));
    accept       = io_in_valid & io_in_ready;
    io_dp_valid  = (state == LAUNCH) & ~io_flush;
    io_out_valid = (state == DONE);
    io_busy      = (state != IDLE);
    capture      = (state == CALC) & (cnt == LAT_CNT) & ~io_flush;
  end

  // Operand signedness decode; opcodes 5-7 fall through to plain MUL.
  always_comb begin
    src1_signed = 1'b0;
    src2_signed = 1'b0;
    is_word     = 1'b0;
    case (io_in_op)
      OP_MULH: begin
        src1_signed = 1'b1;
        src2_signed = 1'b1;
      end
      OP_MULHSU: src1_signed = 1'b1;
      OP_MULW:   is_word     = 1'b1;
      default: begin
        src1_signed = 1'b0;
        src2_signed = 1'b0;
      end
    endcase
  end

  // Next-state and latency counter.
  // LATENCY==1 still takes one CALC cycle so the product is sampled at launch+LATENCY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = 4'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = LAUNCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      LAUNCH: begin
        state_nxt = CALC;
        cnt_nxt   = 4'd1;
      end
      CALC: begin
        if (cnt == LAT_CNT) begin
          state_nxt = DONE;
          cnt_nxt   = 4'd0;
        end else begin
          state_nxt = CALC;
          cnt_nxt   = cnt + 4'd1;
        end
      end
      DONE: begin
        if (io_out_ready) begin
          if (accept) begin
            state_nxt = LAUNCH;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
    if (io_flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      cnt_nxt = cnt_nxt;
    end
  end

  // State register and latency counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Opcode and extended operands; held from launch until the next accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      op         <= 3'd0;
      io_dp_src1 <= 66'd0;
      io_dp_src2 <= 66'd0;
    end else if (accept) begin
      op         <= io_in_op;
      io_dp_src1 <= extend_operand(io_in_src1, src1_signed, is_word);
      io_dp_src2 <= extend_operand(io_in_src2, src2_signed, is_word);
    end else begin
      op <= op;
    end
  end

  // Result register; the datapath bus is only trusted in the capture cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_out_result <= 64'd0;
    end else if (capture) begin
      io_out_result <= select_result(op, io_dp_res[127:0]);
    end else begin
      io_out_result <= io_out_result;
    end
  end

endmodule
